wb_unit: RTL and testbench

Writeback stage placed directly upstream of the 32x64 integer register file. It accepts completed results from the execute unit (EXU) and load responses from the load/store unit (LSU) over valid/ready handshakes, and arbitrates between them with bounded starvation. It aligns and sign/zero-extends load data and drives the register file's single write port from registers. It also keeps a 32-bit busy scoreboard so issue logic can detect pending writes.

---
 rtl/wb_unit.sv | 125 ++++++++++++
 tb/tb_wb_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: EXU/LSU arbitration, load formatting, register file write port, busy scoreboard
//
// Purpose:
//   Accepts EXU results and LSU load responses over valid/ready handshakes.
//   LSU normally has priority. EXU is forced through after STARVE_LIMIT
//   consecutive LSU grants while it waits. Load data is aligned and extended.
//   The single register file write port is driven from registers.
//   A 32-bit busy scoreboard tracks pending destination writes.
//
// Ports:
//   clock, reset                   clock; asynchronous active-high reset
//   exu_valid/ready/rd/data        EXU result handshake and payload
//   lsu_valid/ready/rd/rdata       LSU load response handshake and raw doubleword
//   lsu_size/unsigned/offset       load width, extension mode, byte offset
//   iss_valid, iss_rd              issue-time destination reservation
//   wen, wAddr, wData              registered register file write port
//   busy                           scoreboard, bit i = write to xi pending
module wb_unit #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [4:0]  exu_rd,
  input  logic [63:0] exu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_rdata,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [2:0]  lsu_offset,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        wen,
  output logic [4:0]  wAddr,
  output logic [63:0] wData,
  output logic [31:0] busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        grant_exu;
  logic        grant_lsu;
  logic [5:0]  shamt;
  logic [63:0] sh;
  logic [63:0] load_fmt;
  logic [4:0]  sel_rd;
  logic [63:0] sel_data;
  logic [31:0] busy_q;
  logic [31:0] busy_next;

  // EXU wins when it is alone or when it has waited through LIMIT LSU grants.
  assign grant_exu = exu_valid && (!lsu_valid || (starve_cnt == LIMIT));
  assign grant_lsu = lsu_valid && !grant_exu;
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!exu_valid || grant_exu) begin
      starve_cnt <= 4'd0;
    end else if (grant_lsu && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // A doubleword load uses the whole word, so its offset is ignored.
  assign shamt = (lsu_size == 2'd3) ? 6'd0 : {lsu_offset, 3'b000};
  assign sh    = lsu_rdata >> shamt;

  always_comb begin
    load_fmt = sh;
    case (lsu_size)
      2'd0:    load_fmt = {{56{~lsu_unsigned & sh[7]}},  sh[7:0]};
      2'd1:    load_fmt = {{48{~lsu_unsigned & sh[15]}}, sh[15:0]};
      2'd2:    load_fmt = {{32{~lsu_unsigned & sh[31]}}, sh[31:0]};
      default: load_fmt = sh;
    endcase
  end

  assign sel_rd   = grant_exu ? exu_rd   : lsu_rd;
  assign sel_data = grant_exu ? exu_data : load_fmt;

  // Address and data hold between writebacks; only wen pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wen   <= 1'b0;
      wAddr <= 5'd0;
      wData <= 64'd0;
    end else if (grant_exu || grant_lsu) begin
      wen   <= (sel_rd != 5'd0);
      wAddr <= sel_rd;
      wData <= sel_data;
    end else begin
      wen   <= 1'b0;
    end
  end

  // The clear is applied before the set, so a same-edge reissue keeps the bit set.
  always_comb begin
    busy_next = busy_q;
    if (wen) begin
      busy_next[wAddr] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - self-checking bench for wb_unit against a behavioural model
module tb_wb_unit;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_rdata;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [2:0]  lsu_offset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wen;
  logic [4:0]  wAddr;
  logic [63:0] wData;
  logic [31:0] busy;

  wb_unit #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_offset(lsu_offset),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wen(wen), .wAddr(wAddr), .wData(wData), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  logic [31:0] m_busy;
  int          m_waited;   // LSU wins in a row while EXU has been waiting
  logic        last_ge;
  logic        last_gl;

  function automatic logic [63:0] fmt(input logic [63:0] rdata, input logic [1:0] size,
                                      input logic uns, input logic [2:0] off);
    int          nbytes;
    int          shift;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << size;
    shift  = (size == 2'd3) ? 0 : 8 * int'(off);
    v      = rdata >> shift;
    mask   = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (nbytes * 8)) - 64'd1);
    v      = v & mask;
    if (!uns && v[nbytes * 8 - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_wen = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_waited = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic        ge;
    logic        gl;
    logic [31:0] b;
    ge = exu_valid && (!lsu_valid || m_waited >= LIMIT);
    gl = lsu_valid && !ge;
    @(negedge clock);
    check("exu_ready", exu_ready, ge);
    check("lsu_ready", lsu_ready, gl);
    check("wen", wen, m_wen);
    check("wAddr", wAddr, m_waddr);
    check("wData", wData, m_wdata);
    check("busy", busy, m_busy);
    last_ge = exu_ready;
    last_gl = lsu_ready;
    @(posedge clock);
    b = m_busy;
    if (m_wen) b[m_waddr] = 1'b0;
    if (iss_valid && iss_rd != 0) b[iss_rd] = 1'b1;
    m_busy = b;
    if (ge) begin
      m_wen = (exu_rd != 0); m_waddr = exu_rd; m_wdata = exu_data;
    end else if (gl) begin
      m_wen = (lsu_rd != 0); m_waddr = lsu_rd;
      m_wdata = fmt(lsu_rdata, lsu_size, lsu_unsigned, lsu_offset);
    end else begin
      m_wen = 0;
    end
    if (!exu_valid || ge) m_waited = 0;
    else if (gl && m_waited < LIMIT) m_waited = m_waited + 1;
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_size = 0; lsu_unsigned = 0; lsu_offset = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic new_exu();
    exu_rd   = 5'($urandom_range(0, 31));
    exu_data = {$urandom, $urandom};
  endtask

  task automatic new_lsu();
    lsu_rd       = 5'($urandom_range(0, 31));
    lsu_rdata    = {$urandom, $urandom};
    lsu_size     = 2'($urandom_range(0, 3));
    lsu_unsigned = 1'($urandom_range(0, 1));
    lsu_offset   = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic [9:0] seq;

    idle_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_wen", wen, 0);
    check("rst_busy", busy, 0);
    reset = 0;

    // EXU only, rd=5
    exu_valid = 1; exu_rd = 5; exu_data = 64'h1234;
    step();
    check("exu_wen", wen, 1);
    check("exu_waddr", wAddr, 5);
    check("exu_wdata", wData, 64'h1234);
    // rd=0 completes the handshake without a write
    exu_rd = 0; exu_data = 64'h5555;
    step();
    check("exu_rd0_wen", wen, 0);
    exu_valid = 0;
    step();

    // Load extension vectors
    lsu_valid = 1; lsu_rd = 3; lsu_rdata = 64'h80FF_0000_0000_0000;
    lsu_size = 0; lsu_unsigned = 0; lsu_offset = 7;
    step();
    check("ld_byte_signed", wData, 64'hFFFF_FFFF_FFFF_FF80);
    lsu_unsigned = 1;
    step();
    check("ld_byte_unsigned", wData, 64'h80);
    lsu_unsigned = 0; lsu_offset = 6; lsu_size = 1;
    step();
    check("ld_half_signed", wData, 64'hFFFF_FFFF_FFFF_80FF);
    lsu_valid = 0;
    step();

    // Starvation: both valid continuously, new payload after each grant
    exu_valid = 1; lsu_valid = 1; new_exu(); new_lsu();
    seq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seq[i] = last_ge;
      if (last_ge) new_exu();
      if (last_gl) new_lsu();
    end
    check("starve_seq", seq, 10'b10000_10000);
    idle_inputs();
    step();

    // Scoreboard
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0;
    check("sb_set", busy[7], 1);
    exu_valid = 1; exu_rd = 7; exu_data = 64'hABCD;
    step();
    exu_valid = 0; iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0;
    check("sb_set_wins", busy[7], 1);
    step();
    exu_valid = 1; exu_rd = 7;
    step();
    exu_valid = 0;
    step();
    check("sb_clear", busy[7], 0);
    iss_valid = 1; iss_rd = 9;
    step();
    iss_rd = 0;
    step();
    iss_valid = 0;
    check("sb_rd0", busy, 32'h200);

    // Backpressure: EXU held while LSU occupies three cycles
    exu_valid = 1; exu_rd = 12; exu_data = 64'hFEED;
    lsu_valid = 1; new_lsu(); lsu_rd = 13;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_lsu_first", last_gl, 1);
      if (i == 1) begin lsu_rd = 14; end
      if (i == 2) lsu_valid = 0;
    end
    step();
    check("bp_exu_granted", last_ge, 1);
    exu_valid = 0;
    step();
    check("bp_exu_write", wData, 64'hFEED);
    step();

    // Randomized traffic obeying the hold rule
    for (int i = 0; i < 3000; i++) begin
      if (!exu_valid || last_ge) begin
        exu_valid = 1'($urandom_range(0, 3) != 0);
        new_exu();
      end
      if (!lsu_valid || last_gl) begin
        lsu_valid = 1'($urandom_range(0, 3) != 0);
        new_lsu();
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 31));
      last_ge = 0; last_gl = 0;
      step();
    end

    // Asynchronous reset mid-cycle with a write and scoreboard bits pending
    exu_valid = 1; exu_rd = 21; exu_data = 64'h77; lsu_valid = 0;
    iss_valid = 1; iss_rd = 22;
    step();
    idle_inputs();
    #2;
    reset = 1;
    #1;
    check("arst_wen", wen, 0);
    check("arst_waddr", wAddr, 0);
    check("arst_wdata", wData, 0);
    check("arst_busy", busy, 0);
    model_reset();
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    exu_valid = 1; exu_rd = 2; exu_data = 64'h99;
    step();
    exu_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
